// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_ctrl_pkg
// Description : Shared types and encodings for the multicycle ARM control unit
// Revision    : 1.0 - initial release
// ============================================================================
package arm_ctrl_pkg;

  // Main FSM state codes; codes 10-15 are unused
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } statetype;

  // Instruction class, bits [27:26]; 2'b11 is undefined
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_main_fsm
// Description : Moore main state machine sequencing the multicycle ARM
//               datapath through fetch/decode/execute/memory/writeback.
//               RegW/MemW/Branch are unconditioned requests.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_main_fsm
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [3:0] state
);

  logic [3:0] r_state;
  logic [3:0] w_next;

  // Only I (bit 5) and L (bit 0) steer the sequence; the rest belongs to the ALU decoder
  logic w_unused_funct;
  assign w_unused_funct = &{1'b0, Funct[4:1]};

  // State register; reset drops any in-flight instruction and returns to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic; Op/Funct are only consulted in DECODE and MEMADR
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  w_next = MEMADR;
          OP_DP:   w_next = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = MEMWB;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      default:  w_next = FETCH;
    endcase
  end

  // Moore output decode; unlisted outputs and unused codes stay all-zero
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ALUOp     = 1'b0;
    ResultSrc = RES_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    case (r_state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
      end
      DECODE: begin
        // second PC+4 gives the architectural PC+8
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_RDATA;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        ALUOp = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_main_fsm
// Description : Self-checking bench for multicycle_main_fsm: directed
//               instruction classes, mid-instruction reset, random streams
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .state     (state)
  );

  always #5 clk = ~clk;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ALUOp,ResultSrc,NextPC,RegW,MemW,Branch}
  logic [11:0] w_outs;
  assign w_outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
                   NextPC, RegW, MemW, Branch};

  // Control word each state must present, straight from the state table
  function automatic logic [11:0] exp_outs(input int s);
    case (s)
      0:       return 12'b1_0_1_10_0_10_1_000;
      1:       return 12'b0_0_1_10_0_10_0_000;
      2:       return 12'b0_0_0_01_0_00_0_000;
      3:       return 12'b0_1_0_00_0_00_0_000;
      4:       return 12'b0_0_0_00_0_01_0_100;
      5:       return 12'b0_1_0_00_0_00_0_010;
      6:       return 12'b0_0_0_00_1_00_0_000;
      7:       return 12'b0_0_0_01_1_00_0_000;
      8:       return 12'b0_0_0_00_0_00_0_100;
      9:       return 12'b0_0_0_01_0_10_0_001;
      default: return 12'b0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Run one instruction from FETCH back to FETCH, checking every cycle
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f);
    int seq[$];
    int n_irw = 0, n_npc = 0, n_rw = 0, n_mw = 0, n_br = 0;
    int e_rw = 0, e_mw = 0, e_br = 0;
    case (op)
      2'b00: begin seq = f[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8}; e_rw = 1; end
      2'b01: begin
        if (f[0]) begin seq = '{0, 1, 2, 3, 4}; e_rw = 1; end
        else      begin seq = '{0, 1, 2, 5};    e_mw = 1; end
      end
      2'b10:   begin seq = '{0, 1, 9}; e_br = 1; end
      default: seq = '{0, 1};
    endcase
    Op    = op;
    Funct = f;
    foreach (seq[i]) begin
      check_eq("state", {28'b0, state}, seq[i]);
      check_eq("outs", {20'b0, w_outs}, {20'b0, exp_outs(seq[i])});
      check_eq("strobe_excl", ((32'(RegW) + 32'(MemW) + 32'(Branch)) <= 1) ? 1 : 0, 1);
      n_irw += 32'(IRWrite);
      n_npc += 32'(NextPC);
      n_rw  += 32'(RegW);
      n_mw  += 32'(MemW);
      n_br  += 32'(Branch);
      // past the sampling states the IR inputs are don't-care
      if (seq[i] >= 3) begin
        Op    = 2'($urandom);
        Funct = 6'($urandom);
      end
      @(posedge clk);
      #1;
    end
    check_eq("irwrite_cnt", n_irw, 1);
    check_eq("nextpc_cnt", n_npc, 1);
    check_eq("regw_cnt", n_rw, e_rw);
    check_eq("memw_cnt", n_mw, e_mw);
    check_eq("branch_cnt", n_br, e_br);
  endtask

  initial begin
    reset = 1'b1;
    Op    = 2'b11;
    Funct = 6'b0;
    #2;
    check_eq("reset_state", {28'b0, state}, 0);
    check_eq("reset_outs", {20'b0, w_outs}, {20'b0, exp_outs(0)});
    @(posedge clk);
    #1;
    check_eq("reset_hold", {28'b0, state}, 0);
    #2;
    reset = 1'b0;

    // directed: ADDI, LDR, STR, B, undefined
    run_instr(2'b00, 6'b001000);
    run_instr(2'b01, 6'b011001);
    run_instr(2'b01, 6'b011000);
    run_instr(2'b10, 6'b000000);
    run_instr(2'b11, 6'b111111);
    run_instr(2'b00, 6'b000100);

    // reset while in MEMREAD: asynchronous return to FETCH, no strobes
    Op    = 2'b01;
    Funct = 6'b000001;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("pre_reset_state", {28'b0, state}, 3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_state", {28'b0, state}, 0);
    check_eq("async_reset_outs", {20'b0, w_outs}, {20'b0, exp_outs(0)});
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("rst_state", {28'b0, state}, 0);
      check_eq("rst_strobes", {29'b0, RegW, MemW, Branch}, 0);
    end
    reset = 1'b0;

    // random instruction stream
    for (int k = 0; k < 300; k++) begin
      run_instr(2'($urandom_range(0, 3)), 6'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
